// File: rtl/fb_frame_aligner_pkg.sv
// -----------------------------------------------------------------------------
// fb_frame_aligner_pkg
// Shared definitions for the filterbank frame aligner:
//   align_state_t : alignment FSM state encoding (SEEK / FILL)
//   bit_reverse() : reverses the low 'logn' bits of a channel index
// -----------------------------------------------------------------------------
package fb_frame_aligner_pkg;

  typedef enum logic {
    SEEK = 1'b0,  // waiting for a channel-0 sample
    FILL = 1'b1   // collecting channels 1..N-1 of the current frame
  } align_state_t;

  // Widest channel index the bit-reverse helper supports.
  localparam int MAX_LOGN = 16;

  // Reverse the low 'logn' bits of 'value'; bits above logn come back zero.
  // Shifting avoids variable bit-selects so the loop unrolls cleanly.
  function automatic logic [MAX_LOGN-1:0] bit_reverse(input logic [MAX_LOGN-1:0] value,
                                                      input int                  logn);
    logic [MAX_LOGN-1:0] rev;
    logic [MAX_LOGN-1:0] src;
    rev = '0;
    src = value;
    for (int i = 0; i < MAX_LOGN; i++) begin
      if (i < logn) begin
        rev = {rev[MAX_LOGN-2:0], src[0]};
        src = src >> 1;
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/fb_pingpong_ram.sv
// -----------------------------------------------------------------------------
// fb_pingpong_ram
// 2^AW x WDTH buffer holding both ping-pong banks (bank = MSB of the address).
//   clk, rst          : clock, async active-high reset (read register only)
//   wr_en/addr/data   : single write port
//   rd_en/addr        : read request; rd_data updates one cycle later and holds
//                       its value while rd_en is low
// -----------------------------------------------------------------------------
module fb_pingpong_ram #(
  parameter int AW   = 4,
  parameter int WDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [WDTH-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [WDTH-1:0] rd_data
);

  logic [WDTH-1:0] mem [0:(1<<AW)-1];

  // NOTE: the storage array is deliberately left out of reset; a reset on every
  // word would prevent RAM inference, and no word is read before it is written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The output register is reset so out_data reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fb_frame_aligner.sv
// -----------------------------------------------------------------------------
// fb_frame_aligner
// Aligns a filterbank sample stream to frame boundaries (in_first marks
// channel 0), buffers each complete N-channel frame in a ping-pong RAM and
// replays it as N gapless samples, in bit-reversed or natural channel order.
//   in_data/in_nd/in_m/in_first : input sample, valid, metadata, channel-0 flag
//   in_error                    : upstream error, folded into sticky 'error'
//   out_data/out_nd/out_first   : reordered sample, valid pulse, frame start
//   out_m                       : metadata of the frame's channel-0 sample
//   out_index                   : source channel of out_data
//   error                       : sticky alignment/overflow/upstream error
// -----------------------------------------------------------------------------
module fb_frame_aligner
  import fb_frame_aligner_pkg::*;
#(
  parameter int N      = 8,
  parameter int LOGN   = 3,
  parameter int WDTH   = 32,
  parameter int MWDTH  = 1,
  parameter int BITREV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WDTH-1:0]  in_data,
  input  logic             in_nd,
  input  logic [MWDTH-1:0] in_m,
  input  logic             in_first,
  input  logic             in_error,
  output logic [WDTH-1:0]  out_data,
  output logic             out_nd,
  output logic [MWDTH-1:0] out_m,
  output logic             out_first,
  output logic [LOGN-1:0]  out_index,
  output logic             error
);

  localparam logic [LOGN-1:0] LAST_SLOT = LOGN'(N - 1);

  // Writer side
  align_state_t     state_q, state_d;
  logic [LOGN-1:0]  count_q, count_d;
  logic             wr_bank_q;
  logic [LOGN-1:0]  wr_slot;
  logic             wants_write, wr_en, overflow, proto_err, frame_done;
  logic [MWDTH-1:0] meta_q [2];

  // Bank status and reader side
  logic [1:0]       full_q, full_d;
  logic             rd_bank_q;
  logic [LOGN-1:0]  rd_k_q;
  logic [LOGN-1:0]  rd_slot;
  logic             rd_go, rd_last;

  // ---------------------------------------------------------------------------
  // FSM output decode: which slot this sample targets and which error fires.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wants_write = 1'b0;
    wr_slot     = '0;
    proto_err   = 1'b0;
    if (in_nd) begin
      unique case (state_q)
        SEEK: wants_write = in_first;
        FILL: begin
          if (in_first) begin
            // Early channel 0: abandon the partial frame and restart it.
            wants_write = 1'b1;
            proto_err   = (count_q != '0);
          end else if (count_q == '0) begin
            // Frame boundary without channel 0: lost alignment.
            proto_err   = 1'b1;
          end else begin
            wants_write = 1'b1;
            wr_slot     = count_q;
          end
        end
        default: ;
      endcase
    end
    // The write bank may still hold a frame the reader has not drained.
    overflow   = wants_write && full_q[wr_bank_q];
    wr_en      = wants_write && !overflow;
    frame_done = wr_en && (wr_slot == LAST_SLOT);
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (overflow || (proto_err && !wr_en)) begin
      state_d = SEEK;
      count_d = '0;
    end else if (wr_en) begin
      state_d = FILL;
      count_d = wr_slot + LOGN'(1);  // wraps to 0 after slot N-1
    end
  end

  // ---------------------------------------------------------------------------
  // Reader: drains the bank it points at whenever that bank is full.
  // ---------------------------------------------------------------------------
  assign rd_go   = full_q[rd_bank_q];
  assign rd_last = rd_go && (rd_k_q == LAST_SLOT);
  assign rd_slot = (BITREV != 0) ? LOGN'(bit_reverse(MAX_LOGN'(rd_k_q), LOGN)) : rd_k_q;

  // Writer and reader never touch the same bank's flag in one cycle: the
  // writer only completes an empty bank, the reader only clears a full one.
  always_comb begin
    full_d = full_q;
    if (rd_last)    full_d[rd_bank_q] = 1'b0;
    if (frame_done) full_d[wr_bank_q] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State register, bank pointers and output registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values; combinational blocks above use blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEEK;
      count_q   <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      rd_bank_q <= 1'b0;
      rd_k_q    <= '0;
      out_nd    <= 1'b0;
      out_first <= 1'b0;
      out_index <= '0;
      out_m     <= '0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      full_q    <= full_d;
      if (frame_done) wr_bank_q <= ~wr_bank_q;
      if (rd_go) begin
        rd_k_q    <= rd_k_q + LOGN'(1);
        out_index <= rd_slot;
        out_m     <= meta_q[rd_bank_q];
      end
      if (rd_last) rd_bank_q <= ~rd_bank_q;
      // out_nd/out_first line up with the registered RAM read data.
      out_nd    <= rd_go;
      out_first <= rd_go && (rd_k_q == '0);
      error     <= error | proto_err | overflow | in_error;
    end
  end

  // Per-bank metadata captured with channel 0.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_slot == '0)) meta_q[wr_bank_q] <= in_m;
  end

  fb_pingpong_ram #(
    .AW   (LOGN + 1),
    .WDTH (WDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank_q, wr_slot}),
    .wr_data (in_data),
    .rd_en   (rd_go),
    .rd_addr ({rd_bank_q, rd_slot}),
    .rd_data (out_data)
  );

endmodule

// File: doc/fb_frame_aligner.md
FB_FRAME_ALIGNER -- requirements
Module: fb_frame_aligner

Interface
REQ-001 Parameter N, default 8: channels per frame (power of 2, >=2).
REQ-002 Parameter LOGN, default 3: log2(N).
REQ-003 Parameter WDTH, default 32: complex sample width (re high half, im low half).
REQ-004 Parameter MWDTH, default 1: metadata width.
REQ-005 Parameter BITREV, default 1: 1 = output channels in bit-reversed order (FFT feed); 0 = natural order.
REQ-006 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-007 Ports: rst  in  1  asynchronous, active-high reset.
REQ-008 Ports: in_data  in  WDTH  filterbank output sample.
REQ-009 Ports: in_nd  in  1  in_data/in_m/in_first valid this cycle.
REQ-010 Ports: in_m  in  MWDTH  metadata accompanying sample.
REQ-011 Ports: in_first  in  1  sample is channel 0 of a frame (filterbank first_filter).
REQ-012 Ports: in_error  in  1  upstream filterbank error flag.
REQ-013 Ports: out_data  out  WDTH  reordered sample.
REQ-014 Ports: out_nd  out  1  out_data valid, one-cycle pulse per sample.
REQ-015 Ports: out_m  out  MWDTH  metadata of the frame's channel-0 sample, held for whole frame.
REQ-016 Ports: out_first  out  1  high with first sample of each output frame.
REQ-017 Ports: out_index  out  LOGN  source channel index of out_data.
REQ-018 Ports: error  out  1  sticky error.

Function
REQ-019 Alignment FSM states: SEEK, FILL; reset enters SEEK.
REQ-020 SEEK: samples without in_first discarded; in_nd && in_first writes sample to channel slot 0, count=1, goes FILL.
REQ-021 FILL: each in_nd writes sample to slot count, count increments mod N.
REQ-022 FILL: in_nd && in_first with count!=0 -> error set, partial frame discarded, sample taken as new channel 0 (count=1, stays FILL).
REQ-023 FILL: in_nd && !in_first with count==0 -> error set, sample discarded, go SEEK.
REQ-024 Storage: ping-pong buffer, 2 banks x N words of WDTH; writer fills one bank, reader drains the other.
REQ-025 Writing slot N-1 marks the write bank full and swaps the write bank; in_m of slot 0 is latched per bank.
REQ-026 Overflow: in_nd targeting a bank still full (unread) -> error set, sample dropped, FSM to SEEK.
REQ-027 Reader idle until a bank is full; then emits one sample per cycle for N consecutive cycles, no gaps.
REQ-028 Read order k=0..N-1: slot bitrev(k) if BITREV=1, else slot k; out_index = slot read.
REQ-029 Latency: first out_nd exactly 2 cycles after the in_nd cycle writing slot N-1, reader idle.
REQ-030 Bank cleared (not full) in the cycle its last sample is read; reader may begin other full bank next cycle, back-to-back frames gapless.
REQ-031 out_first high only with k=0; out_m constant across the frame's N outputs.
REQ-032 error is OR of REQ-022/023/026 events and registered in_error; stays set until reset.
REQ-033 out_data/out_index/out_m hold last values when out_nd low.
REQ-034 Simultaneous write and read of different banks in the same cycle fully supported.

Reset
REQ-035 On rst: FSM=SEEK, count=0, both banks not full, write bank=0, reader idle.
REQ-036 On rst: out_nd=0, out_first=0, error=0, out_data=0, out_index=0, out_m=0.
REQ-037 Reset mid-frame discards all buffered and partially emitted frames; no out_nd after rst asserts.
REQ-038 Buffer RAM contents need not be reset.

Structure
REQ-039 Shared package holds FSM state encoding and a bit-reverse function parameterised by LOGN.
REQ-040 One sub-module: fb_pingpong_ram (2N x WDTH, one write port, one registered read port).

Verification (N=8, BITREV=1 unless stated)
REQ-041 Eight in_nd samples 0..7, in_first on 0, in_m=1 -> out_data 0,4,2,6,1,5,3,7 on 8 consecutive cycles, out_first on first, out_m=1, first out 2 cycles after sample 7.
REQ-042 Three samples without in_first, then aligned frame 10..17 -> only 10..17 frame emitted, error=0.
REQ-043 in_first at count=5 -> error=1 sticky; partial frame never output; following frame from new first emitted complete.
REQ-044 Continuous in_nd every cycle for 4 frames, BITREV=0 -> 32 gapless outputs in natural order, out_index 0..7 repeating.
REQ-045 rst asserted 3 cycles into output of a frame -> out_nd low same cycle onward; all outputs zero; resumes only after new in_first.
REQ-046 in_error pulse one cycle -> error=1 and stays high; data flow unaffected.
